delay_line_mc: RTL



---
 rtl/delay_line_pkg.sv | 16 +
 rtl/dl_stage.sv | 28 ++
 rtl/delay_line_mc.sv | 108 ++++++++++
 3 files changed

// File: rtl/delay_line_pkg.sv
// Shared helpers for the multi-channel programmable delay line.
// Covers the width of the delay/count fields and the clamping of requested delays.
package delay_line_pkg;

   function automatic int unsigned cnt_width(input int unsigned depth);
      return $clog2(depth + 1);
   endfunction

   // Out-of-range requests snap to the nearest legal delay instead of being rejected.
   function automatic int unsigned clamp_delay(input int unsigned req, input int unsigned depth);
      if (req == 0) return 1;
      if (req > depth) return depth;
      return req;
   endfunction

endpackage

// File: rtl/dl_stage.sv
// One delay stage: data plus valid, registered on enable. Zero added latency beyond its own flop.
// A clear drops only the valid bit, so a stall or flush never disturbs the data register.
module dl_stage #(
   parameter int DW = 8
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          en,
   input  logic          clr,
   input  logic          in_valid,
   input  logic [DW-1:0] in_data,
   output logic          out_valid,
   output logic [DW-1:0] out_data
);

   always_ff @(posedge clk) begin
      if (rst) begin
         out_valid <= 1'b0;
         out_data  <= '0;
      end else if (clr) begin
         out_valid <= 1'b0;
      end else if (en) begin
         out_valid <= in_valid;
         out_data  <= in_data;
      end
   end

endmodule

// File: rtl/delay_line_mc.sv
// NCH-lane delay line with runtime delay D (1..DEPTH); output taps stage D-1 combinationally.
// i_en low freezes everything (each stalled cycle adds one cycle of latency); flush/delay write drop all samples.
module delay_line_mc
   import delay_line_pkg::*;
#(
   parameter int WIDTH     = 8,
   parameter int NCH       = 2,
   parameter int DEPTH     = 4,
   parameter int DEF_DELAY = DEPTH
) (
   input  logic                             clk,
   input  logic                             rst,
   input  logic                             i_en,
   input  logic                             i_valid,
   input  logic [NCH*WIDTH-1:0]             i_data,
   input  logic                             i_flush,
   input  logic                             i_delay_we,
   input  logic [$clog2(DEPTH+1)-1:0]       i_delay,
   output logic [NCH*WIDTH-1:0]             o_data,
   output logic                             o_valid,
   output logic [$clog2(DEPTH+1)-1:0]       o_count,
   output logic                             o_full,
   output logic [$clog2(DEPTH+1)-1:0]       o_delay
);

   localparam int DW    = int'(cnt_width(DEPTH));
   localparam int DAT_W = NCH * WIDTH;
   localparam logic [DW-1:0] DEF_D = DW'(clamp_delay(DEF_DELAY, DEPTH));

   typedef struct packed {
      logic             valid;
      logic [DAT_W-1:0] data;
   } stage_t;

   logic             stg_vld [DEPTH];
   logic [DAT_W-1:0] stg_dat [DEPTH];
   logic [DW-1:0]    delay_q;
   logic [DW-1:0]    count_q;
   logic             clr;
   logic             shift;
   stage_t           out_sel;

   // A delay write always implies a flush, so both share the valid-clear path.
   assign clr   = i_delay_we | i_flush;
   assign shift = i_en & ~clr;

   for (genvar k = 0; k < DEPTH; k++) begin : g_stage
      if (k == 0) begin : g_head
         dl_stage #(.DW(DAT_W)) u_stage (
            .clk       (clk),
            .rst       (rst),
            .en        (shift),
            .clr       (clr),
            .in_valid  (i_valid),
            .in_data   (i_data),
            .out_valid (stg_vld[k]),
            .out_data  (stg_dat[k])
         );
      end else begin : g_body
         dl_stage #(.DW(DAT_W)) u_stage (
            .clk       (clk),
            .rst       (rst),
            .en        (shift),
            .clr       (clr),
            .in_valid  (stg_vld[k-1]),
            .in_data   (stg_dat[k-1]),
            .out_valid (stg_vld[k]),
            .out_data  (stg_dat[k])
         );
      end
   end

   always_comb begin
      out_sel = '0;
      for (int k = 0; k < DEPTH; k++) begin
         if (k == int'(delay_q) - 1) begin
            out_sel.valid = stg_vld[k];
            out_sel.data  = stg_dat[k];
         end
      end
   end

   // Count tracks valid bits in stages 0..D-1: one enters at stage 0, one leaves past stage D-1.
   always_ff @(posedge clk) begin
      if (rst) begin
         count_q <= '0;
      end else if (clr) begin
         count_q <= '0;
      end else if (i_en) begin
         count_q <= count_q + DW'(i_valid) - DW'(out_sel.valid);
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         delay_q <= DEF_D;
      end else if (i_delay_we) begin
         delay_q <= DW'(clamp_delay(32'(i_delay), DEPTH));
      end
   end

   assign o_data  = out_sel.data;
   assign o_valid = out_sel.valid;
   assign o_count = count_q;
   assign o_full  = (count_q == delay_q);
   assign o_delay = delay_q;

endmodule
